// File: rtl/rtdf_pkg.sv
// rtdf_pkg: shared definitions for the sample unpacker.
//   WORD_W  - width of one word from the packet source (16)
//   ACC_W   - width of the bit accumulator (32, room for two words)
//   FILL_W  - width of the accumulator fill count (holds 0..32)
//   rtdf_state_e - unpacker FSM state encoding
package rtdf_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned FILL_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_STALL = 2'd3
  } rtdf_state_e;

endpackage

// File: rtl/rtdf_bit_accumulator.sv
// rtdf_bit_accumulator: 32-bit LSB-first bit accumulator with fill count.
// Frames are taken from the bottom of the accumulator; new words are
// appended directly above the bits that remain after this cycle's frame.
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_clear         - synchronous discard of all buffered bits
//   i_consume       - remove FRAME_BITS bits from the bottom this cycle
//   i_append        - append i_word above the remaining bits this cycle
//   i_word          - word to append
//   o_frame         - bottom FRAME_BITS bits (the next frame)
//   o_fill          - current number of buffered bits
//   o_fill_after    - fill minus bits consumed this cycle
//   o_fill_next     - fill after consume and append (next-cycle fill)
module rtdf_bit_accumulator
  import rtdf_pkg::*;
#(
  parameter int unsigned FRAME_BITS = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_consume,
  input  logic                  i_append,
  input  logic [WORD_W-1:0]     i_word,
  output logic [FRAME_BITS-1:0] o_frame,
  output logic [FILL_W-1:0]     o_fill,
  output logic [FILL_W-1:0]     o_fill_after,
  output logic [FILL_W-1:0]     o_fill_next
);

  localparam logic [FILL_W-1:0] FB_FILL   = FILL_W'(FRAME_BITS);
  localparam logic [FILL_W-1:0] WORD_FILL = FILL_W'(WORD_W);

  logic [ACC_W-1:0]  r_acc;
  logic [FILL_W-1:0] r_fill;
  logic [ACC_W-1:0]  w_acc_shift;
  logic [ACC_W-1:0]  w_acc_next;

  // Bits at or above r_fill are always zero, so appending is a plain OR.
  always_comb begin
    o_fill_after = r_fill - (i_consume ? FB_FILL : '0);
    o_fill_next  = o_fill_after + (i_append ? WORD_FILL : '0);
    w_acc_shift  = i_consume ? (r_acc >> FRAME_BITS) : r_acc;
    w_acc_next   = w_acc_shift | (i_append ? (ACC_W'(i_word) << o_fill_after) : '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else if (i_clear) begin
      r_acc  <= '0;
      r_fill <= '0;
    end else begin
      r_acc  <= w_acc_next;
      r_fill <= o_fill_next;
    end
  end

  assign o_frame = r_acc[FRAME_BITS-1:0];
  assign o_fill  = r_fill;

endmodule

// File: rtl/rtdf_sample_unpacker.sv
// rtdf_sample_unpacker: unpacks a stream of 16-bit words into frames of
// NUM_CHANNELS x SAMPLE_WIDTH bits, LSB first, frames may straddle words.
// Optional watchdog: define RTDF_WATCHDOG_EN to flush the accumulator after
// WATCHDOG_LIMIT consecutive stall cycles (flush_req tied low otherwise).
//   clk_sample         - clock
//   reset_n            - asynchronous active-low reset
//   enable             - run when high; low returns to IDLE, drops buffered bits
//   packet_empty       - word source empty
//   packet_data        - word source data (first-word-fall-through)
//   packet_read        - combinational pop strobe for the word source
//   sample_valid       - registered, sample_data carries a new frame
//   sample_data        - frame, channel 0 in the least-significant bits
//   total_sample_count - frames emitted since reset (wrapping)
//   underrun_count     - stall cycles since reset (saturating)
//   flush_req          - one-cycle watchdog flush pulse
module rtdf_sample_unpacker
  import rtdf_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH   = 3,
  parameter int unsigned NUM_CHANNELS   = 1,
  parameter int unsigned WATCHDOG_LIMIT = 4096
) (
  input  logic                                 clk_sample,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 packet_empty,
  input  logic [15:0]                          packet_data,
  output logic                                 packet_read,
  output logic                                 sample_valid,
  output logic [SAMPLE_WIDTH*NUM_CHANNELS-1:0] sample_data,
  output logic [31:0]                          total_sample_count,
  output logic [15:0]                          underrun_count,
  output logic                                 flush_req
);

  localparam int unsigned       FRAME_BITS = SAMPLE_WIDTH * NUM_CHANNELS;
  localparam logic [FILL_W-1:0] FB_FILL    = FILL_W'(FRAME_BITS);
  localparam logic [FILL_W-1:0] WORD_FILL  = FILL_W'(WORD_W);

  if (SAMPLE_WIDTH == 0 || SAMPLE_WIDTH > 8 || NUM_CHANNELS == 0 || FRAME_BITS > 16 ||
      WATCHDOG_LIMIT < 2 || WATCHDOG_LIMIT > 65535) begin : g_param_check
    $error("rtdf_sample_unpacker: parameter out of range");
  end

  rtdf_state_e               r_state;
  logic                      r_valid;
  logic [FRAME_BITS-1:0]     r_data;
  logic [31:0]               r_total;
  logic [15:0]               r_under;

  logic                      w_active;
  logic                      w_emit;
  logic                      w_read;
  logic                      w_clear;
  logic                      w_flush_hit;
  logic [FRAME_BITS-1:0]     w_frame;
  logic [FILL_W-1:0]         w_fill;
  logic [FILL_W-1:0]         w_fill_after;
  logic [FILL_W-1:0]         w_fill_next;

  // A word is accepted only when the bits left after this cycle's frame
  // leave room for a whole word; consume and append share the cycle.
  always_comb begin
    w_active = enable && (r_state != ST_IDLE);
    w_emit   = w_active && (r_state == ST_RUN) && (w_fill >= FB_FILL);
    w_read   = w_active && !packet_empty && (w_fill_after <= WORD_FILL) && !w_flush_hit;
    w_clear  = !enable || (r_state == ST_IDLE) || w_flush_hit;
  end

  assign packet_read = w_read;

  rtdf_bit_accumulator #(
    .FRAME_BITS (FRAME_BITS)
  ) u_acc (
    .i_clk        (clk_sample),
    .i_rst_n      (reset_n),
    .i_clear      (w_clear),
    .i_consume    (w_emit),
    .i_append     (w_read),
    .i_word       (packet_data),
    .o_frame      (w_frame),
    .o_fill       (w_fill),
    .o_fill_after (w_fill_after),
    .o_fill_next  (w_fill_next)
  );

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_total <= '0;
      r_under <= '0;
    end else begin
      r_valid <= w_emit;
      if (w_emit) begin
        r_data  <= w_frame;
        r_total <= r_total + 32'd1;
      end
      if ((r_state == ST_STALL) && (r_under != '1)) begin
        r_under <= r_under + 16'd1;
      end
      if (!enable) begin
        r_state <= ST_IDLE;
      end else if (w_flush_hit) begin
        r_state <= ST_FILL;
      end else begin
        case (r_state)
          ST_IDLE:  r_state <= ST_FILL;
          ST_FILL:  r_state <= (w_fill_next >= FB_FILL) ? ST_RUN : ST_FILL;
          ST_RUN:   r_state <= (w_fill_next >= FB_FILL) ? ST_RUN : ST_STALL;
          ST_STALL: r_state <= (w_fill_next >= FB_FILL) ? ST_RUN : ST_STALL;
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef RTDF_WATCHDOG_EN
  logic [15:0] r_wd;
  logic        r_flush;

  // The limit-th consecutive stall cycle triggers the flush; no word is
  // accepted in that cycle so nothing is lost to the clear.
  assign w_flush_hit = enable && (r_state == ST_STALL) && (r_wd == 16'(WATCHDOG_LIMIT - 1));

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      r_wd    <= '0;
      r_flush <= 1'b0;
    end else begin
      r_flush <= w_flush_hit;
      if (enable && (r_state == ST_STALL) && !w_flush_hit) begin
        r_wd <= r_wd + 16'd1;
      end else begin
        r_wd <= '0;
      end
    end
  end

  assign flush_req = r_flush;
`else
  assign w_flush_hit = 1'b0;
  assign flush_req   = 1'b0;
`endif

  assign sample_valid       = r_valid;
  assign sample_data        = r_data;
  assign total_sample_count = r_total;
  assign underrun_count     = r_under;

endmodule

// File: tb/tb_rtdf_sample_unpacker.sv
// Bench for rtdf_sample_unpacker: two instances (3x1 bits and 2x4 bits) fed
// from word queues; an LSB-first bit-stream model predicts every frame.
module tb_rtdf_sample_unpacker;

  logic        clk;
  logic        rst_n;
  logic        en0, en1;
  logic        empty0, empty1;
  logic [15:0] data0, data1;
  logic        rd0, rd1;
  logic        valid0, valid1;
  logic [2:0]  sdata0;
  logic [7:0]  sdata1;
  logic [31:0] total0, total1;
  logic [15:0] under0, under1;
  logic        flush0, flush1;

  rtdf_sample_unpacker #(
    .SAMPLE_WIDTH   (3),
    .NUM_CHANNELS   (1),
    .WATCHDOG_LIMIT (8)
  ) u_dut0 (
    .clk_sample         (clk),
    .reset_n            (rst_n),
    .enable             (en0),
    .packet_empty       (empty0),
    .packet_data        (data0),
    .packet_read        (rd0),
    .sample_valid       (valid0),
    .sample_data        (sdata0),
    .total_sample_count (total0),
    .underrun_count     (under0),
    .flush_req          (flush0)
  );

  rtdf_sample_unpacker #(
    .SAMPLE_WIDTH   (2),
    .NUM_CHANNELS   (4),
    .WATCHDOG_LIMIT (4096)
  ) u_dut1 (
    .clk_sample         (clk),
    .reset_n            (rst_n),
    .enable             (en1),
    .packet_empty       (empty1),
    .packet_data        (data1),
    .packet_read        (rd1),
    .sample_valid       (valid1),
    .sample_data        (sdata1),
    .total_sample_count (total1),
    .underrun_count     (under1),
    .flush_req          (flush1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] srcq0[$], srcq1[$];
  bit          bitq0[$], bitq1[$];
  logic [2:0]  expq0[$];
  logic [7:0]  expq1[$];
  logic [2:0]  last0;
  logic [7:0]  last1;
  int unsigned ngen0, ngen1;
  int          n_checks, n_fail;
  logic        last_r0, last_r1;
  int unsigned base, nval, u_pre, ua, npulse, uat;
  bit          seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    empty0 = (srcq0.size() == 0);
    data0  = (srcq0.size() > 0) ? srcq0[0] : 16'h0000;
    empty1 = (srcq1.size() == 0);
    data1  = (srcq1.size() > 0) ? srcq1[0] : 16'h0000;
  endtask

  task automatic accept0(input logic [15:0] w);
    logic [2:0] f;
    for (int i = 0; i < 16; i++) bitq0.push_back(w[i]);
    while (bitq0.size() >= 3) begin
      for (int j = 0; j < 3; j++) f[j] = bitq0.pop_front();
      expq0.push_back(f);
      ngen0++;
    end
  endtask

  task automatic accept1(input logic [15:0] w);
    logic [7:0] f;
    for (int i = 0; i < 16; i++) bitq1.push_back(w[i]);
    while (bitq1.size() >= 8) begin
      for (int j = 0; j < 8; j++) f[j] = bitq1.pop_front();
      expq1.push_back(f);
      ngen1++;
    end
  endtask

  // One clock: sample the pop strobes mid-cycle, then after the edge update
  // the model, check outputs and present the next source words.
  task automatic step();
    @(negedge clk);
    last_r0 = rd0;
    last_r1 = rd1;
    check("rd0_while_empty", {31'd0, rd0 & empty0}, 32'd0);
    check("rd1_while_empty", {31'd0, rd1 & empty1}, 32'd0);
    @(posedge clk);
    #1;
    if (last_r0) accept0(srcq0.pop_front());
    if (last_r1) accept1(srcq1.pop_front());
    if (valid0) begin
      check("frame0_pending", {31'd0, expq0.size() > 0}, 32'd1);
      if (expq0.size() > 0) begin
        last0 = expq0.pop_front();
        check("frame0", {29'd0, sdata0}, {29'd0, last0});
      end
    end else begin
      check("hold0", {29'd0, sdata0}, {29'd0, last0});
    end
    if (valid1) begin
      check("frame1_pending", {31'd0, expq1.size() > 0}, 32'd1);
      if (expq1.size() > 0) begin
        last1 = expq1.pop_front();
        check("frame1", {24'd0, sdata1}, {24'd0, last1});
      end
    end else begin
      check("hold1", {24'd0, sdata1}, {24'd0, last1});
    end
`ifndef RTDF_WATCHDOG_EN
    check("flush0_tied_low", {31'd0, flush0}, 32'd0);
    check("flush1_tied_low", {31'd0, flush1}, 32'd0);
`endif
    drive();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid0"}, {31'd0, valid0}, 32'd0);
    check({tag, "_data0"},  {29'd0, sdata0}, 32'd0);
    check({tag, "_total0"}, total0, 32'd0);
    check({tag, "_under0"}, {16'd0, under0}, 32'd0);
    check({tag, "_flush0"}, {31'd0, flush0}, 32'd0);
    check({tag, "_rd0"},    {31'd0, rd0}, 32'd0);
    check({tag, "_valid1"}, {31'd0, valid1}, 32'd0);
    check({tag, "_data1"},  {24'd0, sdata1}, 32'd0);
    check({tag, "_total1"}, total1, 32'd0);
    check({tag, "_rd1"},    {31'd0, rd1}, 32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; ngen0 = 0; ngen1 = 0;
    last0 = '0; last1 = '0;
    rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Frames straddling a word boundary (3-bit) and whole-word frames (8-bit).
    srcq0.push_back(16'hFAC6);
    srcq0.push_back(16'h0001);
    srcq1.push_back(16'h1B1B);
    en0 = 1'b1; en1 = 1'b1;
    drive();
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = valid0;
    end
    check("first_frame0_seen", {31'd0, seen}, 32'd1);
    nval = 1;
    repeat (9) begin
      step();
      nval += valid0;
    end
    check("no_gap0", nval, 32'd10);
    check("ch0_of_1B", {30'd0, sdata1[1:0]}, 32'd3);
    check("ch3_of_1B", {30'd0, sdata1[7:6]}, 32'd0);
    check("total1_two_frames", total1, 32'd2);

    // Source starved: five stall cycles, then resume without losing bits.
    base = under0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = (under0 != 16'(base));
    end
    check("stall_started", {31'd0, seen}, 32'd1);
    repeat (3) step();
    srcq0.push_back(16'h5A3C);
    srcq0.push_back(16'h9E71);
    drive();
    repeat (4) step();
    check("underrun_plus5", {16'd0, under0}, base + 5);
    u_pre = under0;
    repeat (12) step();
    check("drained0", expq0.size(), 32'd0);
    check("total0_after_gap", total0, ngen0);

`ifdef RTDF_WATCHDOG_EN
    npulse = 0; uat = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (flush0) begin
        npulse++;
        uat = under0;
      end
    end
    check("wd_pulse_count", npulse, 32'd1);
    check("wd_pulse_8th_stall", uat, u_pre + 8);
    check("wd_stall_ended", {16'd0, under0}, u_pre + 8);
    bitq0.delete();
`else
    ua = under0;
    repeat (16) step();
    check("stall_persists", {16'd0, under0}, ua + 16);
`endif

    // Resume on one instance, disable the other mid-stream.
    srcq0.push_back(16'hC3A5);
    srcq1.push_back(16'hA5C3);
    srcq1.push_back(16'h0FF0);
    srcq1.push_back(16'h7E81);
    srcq1.push_back(16'h3C5A);
    drive();
    repeat (2) step();
    en1 = 1'b0;
    ngen1 -= expq1.size();
    expq1.delete();
    bitq1.delete();
    step();
    check("no_read_on_disable", {31'd0, last_r1}, 32'd0);
    check("no_valid_after_disable", {31'd0, valid1}, 32'd0);
    check("words_kept", srcq1.size(), 32'd2);
    check("total1_retained", total1, ngen1);
    step();
    en1 = 1'b1;
    repeat (12) step();
    check("drained1_reenable", expq1.size(), 32'd0);
    check("total1_reenable", total1, ngen1);
    check("drained0_resume", expq0.size(), 32'd0);
    check("total0_resume", total0, ngen0);

    // Asynchronous reset between edges mid-stream.
    srcq0.push_back(16'h1234);
    srcq0.push_back(16'hABCD);
    srcq1.push_back(16'h55AA);
    srcq1.push_back(16'hF00F);
    drive();
    repeat (3) step();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    srcq0.delete(); srcq1.delete();
    bitq0.delete(); bitq1.delete();
    expq0.delete(); expq1.delete();
    ngen0 = 0; ngen1 = 0; last0 = '0; last1 = '0;
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    srcq0.push_back(16'hFAC6);
    srcq0.push_back(16'h0001);
    srcq1.push_back(16'h1B1B);
    drive();
    repeat (16) step();
    check("post_rst_drained0", expq0.size(), 32'd0);
    check("post_rst_total0", total0, 32'd10);
    check("post_rst_total1", total1, 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
